// File: rtl/icmp_checksum_insert.sv
// Buffers one ICMP message, computes its RFC 1071 checksum and re-emits it with the checksum in word CHK_WORD[15:0].
// Optional: define ICMP_PKT_CNT_EN to add the pkt_count output (count of fully emitted messages).
module icmp_checksum_insert #(
  parameter int MSG_WORDS = 5,
  parameter int CHK_WORD  = 0
) (
  input  logic        clock,
  input  logic        hardreset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  input  logic        out_ready,
  output logic        abort
`ifdef ICMP_PKT_CNT_EN
  ,
  output logic [15:0] pkt_count
`endif
);

  localparam int IW = $clog2(MSG_WORDS);
  // 20 bits holds 16 half-word sums without wrap; longer messages get one extra carry bit
  localparam int ACC_W = (MSG_WORDS > 8) ? 21 : 20;
  localparam logic [IW-1:0] LAST = IW'(MSG_WORDS - 1);
  localparam logic [IW-1:0] CHKI = IW'(CHK_WORD);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FOLD, S_EMIT} state_t;

  state_t            r_state, w_nxt;
  logic [IW-1:0]     r_cnt, r_oidx, w_widx, w_oidx_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [31:0]       r_buf [MSG_WORDS];
  logic [31:0]       r_out_data, w_emit, w_bword;
  logic [16:0]       w_s1;
  logic [15:0]       w_s2, w_chk, r_chk, w_lo, w_sel_chk;
  logic              r_in_ready, w_in_ready_nxt, r_abort;
  logic              r_out_valid, r_out_sof, r_out_eof;
  logic              w_acc_in, w_restart, w_store, w_out_xfer;

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign abort     = r_abort;

  assign w_acc_in   = in_valid & r_in_ready;
  assign w_restart  = w_acc_in & in_sof;
  assign w_store    = w_acc_in & (in_sof | (r_state == S_ACCUM));
  assign w_out_xfer = r_out_valid & out_ready;

  // An sof always lands in slot 0 and restarts the sum; the checksum field contributes zero
  assign w_widx    = in_sof ? '0 : r_cnt;
  assign w_lo      = (w_widx == CHKI) ? 16'h0000 : in_data[15:0];
  assign w_acc_nxt = (in_sof ? '0 : r_acc) + ACC_W'(in_data[31:16]) + ACC_W'(w_lo);

  // Two end-around-carry folds; the second cannot carry out again
  assign w_s1  = {1'b0, r_acc[15:0]} + 17'(r_acc[ACC_W-1:16]);
  assign w_s2  = w_s1[15:0] + 16'(w_s1[16]);
  assign w_chk = ~w_s2;

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) r_state <= S_IDLE;
    else              r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_restart) w_nxt = S_ACCUM;
      S_ACCUM: if (w_acc_in && !in_sof && r_cnt == LAST) w_nxt = S_FOLD;
      S_FOLD:  w_nxt = S_EMIT;
      S_EMIT:  if (w_out_xfer && r_out_eof) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready_nxt = (w_nxt == S_IDLE) || (w_nxt == S_ACCUM);
    w_oidx_nxt     = (r_state == S_FOLD) ? '0 : r_oidx + 1'b1;
    w_sel_chk      = (r_state == S_FOLD) ? w_chk : r_chk;
    w_bword        = r_buf[w_oidx_nxt];
    w_emit         = {w_bword[31:16], (w_oidx_nxt == CHKI) ? w_sel_chk : w_bword[15:0]};
  end

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) begin
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_abort    <= 1'b0;
      r_chk      <= '0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_abort    <= w_restart && (r_state == S_ACCUM);
      if (w_store) begin
        r_cnt <= w_widx + 1'b1;
        r_acc <= w_acc_nxt;
      end
      if (r_state == S_FOLD) r_chk <= w_chk;
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) r_buf[w_widx] <= in_data;
  end

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_oidx      <= '0;
    end else if (r_state == S_FOLD) begin
      r_out_data  <= w_emit;
      r_out_valid <= 1'b1;
      r_out_sof   <= 1'b1;
      r_out_eof   <= 1'b0;
      r_oidx      <= '0;
    end else if (w_out_xfer) begin
      if (r_out_eof) begin
        r_out_valid <= 1'b0;
        r_out_sof   <= 1'b0;
        r_out_eof   <= 1'b0;
      end else begin
        r_out_data <= w_emit;
        r_out_sof  <= 1'b0;
        r_out_eof  <= (w_oidx_nxt == LAST);
        r_oidx     <= w_oidx_nxt;
      end
    end
  end

`ifdef ICMP_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n)                r_pkt_cnt <= '0;
    else if (w_out_xfer && r_out_eof) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign pkt_count = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_icmp_checksum_insert.sv
// Directed bench for icmp_checksum_insert; expected output words are queued at send time and popped by the output monitor.
module tb_icmp_checksum_insert;
  localparam int N = 5;

  logic        clock = 1'b0;
  logic        hardreset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_sof, out_eof, abort;
  logic [31:0] out_data;
`ifdef ICMP_PKT_CNT_EN
  logic [15:0] pkt_count;
`endif

  icmp_checksum_insert #(.MSG_WORDS(N), .CHK_WORD(0)) dut (
    .clock(clock), .hardreset_n(hardreset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_ready(out_ready), .abort(abort)
`ifdef ICMP_PKT_CNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clock = ~clock;

  int          n_pass = 0, n_total = 0, n_abort = 0;
  logic [33:0] q[$];
  logic [31:0] msg[N];
  logic        stall_q = 1'b0;
  logic [33:0] held = '0;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Output monitor: scoreboard pop on transfer, hold check while stalled
  always @(negedge clock) begin
    if (abort === 1'b1) n_abort++;
    if (out_valid === 1'b1) begin
      chk("no_overlap_in_ready", {33'b0, in_ready}, 34'd0);
      if (stall_q) chk("hold_stable", {out_sof, out_eof, out_data}, held);
      if (out_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $error("FAIL unexpected_out: got %h want none", {out_sof, out_eof, out_data});
        end else chk("out_word", {out_sof, out_eof, out_data}, q.pop_front());
      end
      stall_q = !out_ready;
      held    = {out_sof, out_eof, out_data};
    end else stall_q = 1'b0;
  end

  task automatic send_word(input logic [31:0] d, input logic s);
    in_data = d; in_sof = s; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        @(posedge clock); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        return;
      end
    end
    chk("in_ready_timeout", {33'b0, in_ready}, 34'd1);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // Queue the expected words, send msg[], then check the 2-cycle turnaround
  task automatic send_msg(input logic [31:0] exp_w0);
    for (int i = 0; i < N; i++)
      q.push_back({(i == 0), (i == N - 1), (i == 0) ? exp_w0 : msg[i]});
    for (int i = 0; i < N; i++) send_word(msg[i], (i == 0));
    @(negedge clock);
    chk("fold_out_valid", {33'b0, out_valid}, 34'd0);
    chk("fold_in_ready", {33'b0, in_ready}, 34'd0);
    @(negedge clock);
    chk("emit_out_valid", {33'b0, out_valid}, 34'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
    chk("drain", 34'(q.size()), 34'd0);
    @(posedge clock); #1;
  endtask

  task automatic load_basic();
    msg[0] = 32'h08000000; msg[1] = 32'h12340001;
    msg[2] = 32'h0; msg[3] = 32'h0; msg[4] = 32'h0;
  endtask

  initial begin
    int a0;
    #12;
    chk("rst_in_ready",  {33'b0, in_ready},  34'd0);
    chk("rst_out_valid", {33'b0, out_valid}, 34'd0);
    chk("rst_out_sof",   {33'b0, out_sof},   34'd0);
    chk("rst_out_eof",   {33'b0, out_eof},   34'd0);
    chk("rst_abort",     {33'b0, abort},     34'd0);
    chk("rst_out_data",  {2'b0, out_data},   34'd0);
`ifdef ICMP_PKT_CNT_EN
    chk("rst_pkt_count", {18'b0, pkt_count}, 34'd0);
`endif
    @(posedge clock); #1; hardreset_n = 1'b1;
    @(posedge clock); #1;

    // basic message
    load_basic();
    send_msg(32'h0800E5CA);
    drain();

    // carry fold, nonzero checksum field ignored
    msg[0] = 32'h0000ABCD;
    for (int i = 1; i < N; i++) msg[i] = 32'hFFFFFFFF;
    send_msg(32'h00000000);
    drain();

    // backpressure 1,0,0,1,...
    load_basic();
    out_ready = 1'b0;
    send_msg(32'h0800E5CA);
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    drain();

    // abort: partial message then a full one
    a0 = n_abort;
    send_word(32'h11110000, 1'b1);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    load_basic();
    send_msg(32'h0800E5CA);
    drain();
    chk("abort_count", 34'(n_abort - a0), 34'd1);

    // junk before sof
    a0 = n_abort;
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'h01234567, 1'b0);
    send_msg(32'h0800E5CA);
    drain();
    chk("junk_no_abort", 34'(n_abort - a0), 34'd0);

    // reset in the middle of EMIT
    send_msg(32'h0800E5CA);
    for (int i = 0; i < 50 && q.size() > 3; i++) @(negedge clock);
    @(posedge clock); #1;
    hardreset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {33'b0, out_valid}, 34'd0);
    chk("midrst_in_ready",  {33'b0, in_ready},  34'd0);
`ifdef ICMP_PKT_CNT_EN
    chk("midrst_pkt_count", {18'b0, pkt_count}, 34'd0);
`endif
    q.delete();
    @(posedge clock); #1; hardreset_n = 1'b1;
    @(posedge clock); #1;
    send_msg(32'h0800E5CA);
    drain();
`ifdef ICMP_PKT_CNT_EN
    chk("pkt_count_after", {18'b0, pkt_count}, 34'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
